// File: rtl/ddl_pkg.sv
// Shared definitions for the DDL front-end command receiver: command codes,
// command-word field positions and the reply FSM state type.
package ddl_pkg;

   localparam logic [3:0] CmdRdyrx = 4'h1;
   localparam logic [3:0] CmdEobtr = 4'hB;
   localparam logic [3:0] CmdStbrd = 4'hC;
   localparam logic [3:0] CmdStbwr = 4'hD;

   localparam int unsigned CodeLsb  = 0;
   localparam int unsigned CodeW    = 4;
   localparam int unsigned TridLsb  = 4;
   localparam int unsigned TridW    = 4;
   localparam int unsigned ParamLsb = 8;
   localparam int unsigned ParamW   = 19;

   typedef enum logic [1:0] {
      StIdle,
      StTurn,
      StReply,
      StRelease
   } fe_state_t;

   function automatic logic is_defined_cmd(input logic [3:0] code);
      logic defined;
      case (code)
         CmdRdyrx, CmdEobtr, CmdStbrd, CmdStbwr: defined = 1'b1;
         default:                                defined = 1'b0;
      endcase
      return defined;
   endfunction

endpackage

// File: rtl/ddl_sat_cnt.sv
// Parameterised-width up-counter that holds at all-ones instead of wrapping.
module ddl_sat_cnt
   import ddl_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {Width{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ddl_fecmd_rx.sv
// DDL SIU front-end command receiver: decodes RORC command words, tracks the
// transfer grant and answers STBRD with a single status word on the bus.
module ddl_fecmd_rx
   import ddl_pkg::*;
(
   input  logic        siu_foCLK,
   input  logic        siu_reset,
   input  logic [31:0] siu_fbd_in,
   input  logic        siu_fbten_n,
   input  logic        siu_fbctrl_n,
   input  logic        siu_fidir,
   input  logic        siu_filf_n,
   input  logic [15:0] fee_status,
   output logic        rdyrx_pulse,
   output logic        eobtr_pulse,
   output logic        tx_enable,
   output logic [3:0]  cmd_code,
   output logic [3:0]  cmd_trid,
   output logic [18:0] cmd_param,
   output logic [31:0] fbd_out,
   output logic        fbd_oe,
   output logic        fbten_n_out,
   output logic        fbctrl_n_out,
   output logic [15:0] rx_cmd_cnt,
   output logic [7:0]  bad_cmd_cnt
);

   // Asserts immediately with siu_reset, releases two clock edges later.
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge siu_foCLK or posedge siu_reset) begin
      if (siu_reset) begin
         rst_sync_q <= 2'b11;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b0};
      end
   end

   assign rst_int = rst_sync_q[1];

   logic              cmd_acc;
   logic [CodeW-1:0]  code_in;
   logic [TridW-1:0]  trid_in;
   logic [ParamW-1:0] param_in;
   logic              unused_fbd_hi;

   assign cmd_acc       = !siu_fidir && !siu_fbten_n && !siu_fbctrl_n;
   assign code_in       = siu_fbd_in[CodeLsb +: CodeW];
   assign trid_in       = siu_fbd_in[TridLsb +: TridW];
   assign param_in      = siu_fbd_in[ParamLsb +: ParamW];
   assign unused_fbd_hi = ^siu_fbd_in[31:27];

   fe_state_t         state_q, state_d;
   logic              turn_q, turn_d;
   logic              tx_enable_q, tx_enable_d;
   logic              pend_q, pend_d;
   logic [TridW-1:0]  rtrid_q, rtrid_d;
   logic              rdyrx_q, rdyrx_d;
   logic              eobtr_q, eobtr_d;
   logic [CodeW-1:0]  code_q;
   logic [TridW-1:0]  trid_q;
   logic [ParamW-1:0] param_q;
   logic              bad_inc;

   always_comb begin
      tx_enable_d = tx_enable_q;
      pend_d      = pend_q;
      rtrid_d     = rtrid_q;
      rdyrx_d     = 1'b0;
      eobtr_d     = 1'b0;
      bad_inc     = 1'b0;
      if (state_q == StReply) begin
         pend_d = 1'b0;
      end
      if (cmd_acc) begin
         case (code_in)
            CmdRdyrx: begin
               tx_enable_d = 1'b1;
               rdyrx_d     = 1'b1;
            end
            CmdEobtr: begin
               if (tx_enable_q) begin
                  tx_enable_d = 1'b0;
                  eobtr_d     = 1'b1;
               end else begin
                  bad_inc = 1'b1;
               end
            end
            CmdStbrd: begin
               // A repeat while a reply is still owed replaces the trid but is flagged.
               bad_inc = pend_q;
               pend_d  = 1'b1;
               rtrid_d = trid_in;
            end
            CmdStbwr: ;
            default: bad_inc = !is_defined_cmd(code_in);
         endcase
      end
   end

   always_ff @(posedge siu_foCLK or posedge rst_int) begin
      if (rst_int) begin
         tx_enable_q <= 1'b0;
         pend_q      <= 1'b0;
         rtrid_q     <= '0;
         rdyrx_q     <= 1'b0;
         eobtr_q     <= 1'b0;
         code_q      <= '0;
         trid_q      <= '0;
         param_q     <= '0;
      end else begin
         tx_enable_q <= tx_enable_d;
         pend_q      <= pend_d;
         rtrid_q     <= rtrid_d;
         rdyrx_q     <= rdyrx_d;
         eobtr_q     <= eobtr_d;
         if (cmd_acc) begin
            code_q  <= code_in;
            trid_q  <= trid_in;
            param_q <= param_in;
         end
      end
   end

   ddl_sat_cnt #(
      .Width(16)
   ) u_rx_cnt (
      .clk   (siu_foCLK),
      .rst   (rst_int),
      .inc   (cmd_acc),
      .count (rx_cmd_cnt)
   );

   ddl_sat_cnt #(
      .Width(8)
   ) u_bad_cnt (
      .clk   (siu_foCLK),
      .rst   (rst_int),
      .inc   (bad_inc),
      .count (bad_cmd_cnt)
   );

   always_ff @(posedge siu_foCLK or posedge rst_int) begin
      if (rst_int) begin
         state_q <= StIdle;
         turn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      turn_d       = turn_q;
      fbd_oe       = 1'b0;
      fbten_n_out  = 1'b1;
      fbctrl_n_out = 1'b1;
      fbd_out      = '0;
      case (state_q)
         StIdle: begin
            if (pend_q && siu_fidir && siu_filf_n) begin
               state_d = StTurn;
               turn_d  = 1'b0;
            end
         end
         StTurn: begin
            // A full link freezes the turnaround count rather than restarting it.
            if (!siu_fidir) begin
               state_d = StIdle;
            end else if (siu_filf_n) begin
               if (turn_q) begin
                  state_d = StReply;
               end else begin
                  turn_d = 1'b1;
               end
            end
         end
         StReply: begin
            state_d      = StRelease;
            fbd_oe       = 1'b1;
            fbten_n_out  = 1'b0;
            fbctrl_n_out = 1'b0;
            fbd_out      = {fee_status, 4'h0, tx_enable_q, 3'b000, rtrid_q, CmdStbrd};
         end
         StRelease: begin
            if (!siu_fidir) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rdyrx_pulse = rdyrx_q;
   assign eobtr_pulse = eobtr_q;
   assign tx_enable   = tx_enable_q;
   assign cmd_code    = code_q;
   assign cmd_trid    = trid_q;
   assign cmd_param   = param_q;

endmodule

// File: tb/tb_ddl_fecmd_rx.sv
// Directed self-checking bench for ddl_fecmd_rx: command decode, reply
// handshake, turnaround corner cases, reset during reply and counter saturation.
module tb_ddl_fecmd_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fbd_in = '0;
   logic        fbten_n = 1'b1;
   logic        fbctrl_n = 1'b1;
   logic        fidir = 1'b0;
   logic        filf_n = 1'b1;
   logic [15:0] fee_status = 16'hA5A5;
   logic        rdyrx_pulse, eobtr_pulse, tx_enable;
   logic [3:0]  cmd_code, cmd_trid;
   logic [18:0] cmd_param;
   logic [31:0] fbd_out;
   logic        fbd_oe, fbten_n_out, fbctrl_n_out;
   logic [15:0] rx_cmd_cnt;
   logic [7:0]  bad_cmd_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ddl_fecmd_rx dut (
      .siu_foCLK    (clk),
      .siu_reset    (rst),
      .siu_fbd_in   (fbd_in),
      .siu_fbten_n  (fbten_n),
      .siu_fbctrl_n (fbctrl_n),
      .siu_fidir    (fidir),
      .siu_filf_n   (filf_n),
      .fee_status   (fee_status),
      .rdyrx_pulse  (rdyrx_pulse),
      .eobtr_pulse  (eobtr_pulse),
      .tx_enable    (tx_enable),
      .cmd_code     (cmd_code),
      .cmd_trid     (cmd_trid),
      .cmd_param    (cmd_param),
      .fbd_out      (fbd_out),
      .fbd_oe       (fbd_oe),
      .fbten_n_out  (fbten_n_out),
      .fbctrl_n_out (fbctrl_n_out),
      .rx_cmd_cnt   (rx_cmd_cnt),
      .bad_cmd_cnt  (bad_cmd_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one command word for exactly one edge; returns on the following negedge.
   task automatic send_cmd(input logic [31:0] w);
      tick();
      fbd_in   = w;
      fbten_n  = 1'b0;
      fbctrl_n = 1'b0;
      tick();
      fbd_in   = '0;
      fbten_n  = 1'b1;
      fbctrl_n = 1'b1;
   endtask

   task automatic chk_idle_bus(input string tag);
      chk({tag, "_oe"}, {31'd0, fbd_oe}, 32'd0);
      chk({tag, "_ten"}, {31'd0, fbten_n_out}, 32'd1);
      chk({tag, "_data"}, fbd_out, 32'd0);
   endtask

   task automatic chk_reply(input string tag, input logic [31:0] word);
      chk({tag, "_oe"}, {31'd0, fbd_oe}, 32'd1);
      chk({tag, "_ten"}, {31'd0, fbten_n_out}, 32'd0);
      chk({tag, "_ctrl"}, {31'd0, fbctrl_n_out}, 32'd0);
      chk({tag, "_data"}, fbd_out, word);
   endtask

   initial begin
      // Reset state
      #2 rst = 1'b1;
      tick();
      tick();
      chk_idle_bus("rst");
      chk("rst_ctrl", {31'd0, fbctrl_n_out}, 32'd1);
      chk("rst_txen", {31'd0, tx_enable}, 32'd0);
      chk("rst_rxcnt", {16'd0, rx_cmd_cnt}, 32'd0);
      chk("rst_badcnt", {24'd0, bad_cmd_cnt}, 32'd0);
      chk("rst_code", {28'd0, cmd_code}, 32'd0);
      rst = 1'b0;
      repeat (3) tick();

      // Data word (fbctrl_n=1) is ignored
      fbd_in  = 32'h0000_0011;
      fbten_n = 1'b0;
      tick();
      fbten_n = 1'b1;
      fbd_in  = '0;
      chk("data_rxcnt", {16'd0, rx_cmd_cnt}, 32'd0);
      chk("data_txen", {31'd0, tx_enable}, 32'd0);

      // RDYRX trid=1
      send_cmd(32'h0000_0011);
      chk("rdy_code", {28'd0, cmd_code}, 32'd1);
      chk("rdy_trid", {28'd0, cmd_trid}, 32'd1);
      chk("rdy_pulse", {31'd0, rdyrx_pulse}, 32'd1);
      chk("rdy_txen", {31'd0, tx_enable}, 32'd1);
      chk("rdy_rxcnt", {16'd0, rx_cmd_cnt}, 32'd1);
      tick();
      chk("rdy_pulse_end", {31'd0, rdyrx_pulse}, 32'd0);

      // RDYRX while already enabled
      send_cmd(32'h0000_0021);
      chk("rdy2_pulse", {31'd0, rdyrx_pulse}, 32'd1);
      chk("rdy2_txen", {31'd0, tx_enable}, 32'd1);
      chk("rdy2_rxcnt", {16'd0, rx_cmd_cnt}, 32'd2);

      // EOBTR with grant, then repeated without grant
      send_cmd(32'h0000_002B);
      chk("eob_pulse", {31'd0, eobtr_pulse}, 32'd1);
      chk("eob_txen", {31'd0, tx_enable}, 32'd0);
      chk("eob_bad", {24'd0, bad_cmd_cnt}, 32'd0);
      tick();
      chk("eob_pulse_end", {31'd0, eobtr_pulse}, 32'd0);
      send_cmd(32'h0000_002B);
      chk("eob2_pulse", {31'd0, eobtr_pulse}, 32'd0);
      chk("eob2_bad", {24'd0, bad_cmd_cnt}, 32'd1);
      chk("eob2_rxcnt", {16'd0, rx_cmd_cnt}, 32'd4);

      // STBWR with junk in [31:27]: fields latched, no strobe, not bad
      send_cmd(32'hF812_345D);
      chk("stbwr_code", {28'd0, cmd_code}, 32'hD);
      chk("stbwr_trid", {28'd0, cmd_trid}, 32'h5);
      chk("stbwr_param", {13'd0, cmd_param}, 32'h0_1234);
      chk("stbwr_strobes", {30'd0, rdyrx_pulse, eobtr_pulse}, 32'd0);
      chk("stbwr_bad", {24'd0, bad_cmd_cnt}, 32'd1);
      chk("stbwr_rxcnt", {16'd0, rx_cmd_cnt}, 32'd5);

      // STBRD with tx_enable=1, full reply handshake
      send_cmd(32'h0000_0011);
      send_cmd(32'h0000_005C);
      fidir = 1'b1;
      tick();
      chk_idle_bus("turn1");
      tick();
      chk_idle_bus("turn2");
      tick();
      chk_reply("reply_a", 32'hA5A5_085C);
      tick();
      chk_idle_bus("release_a");
      chk("release_a_ctrl", {31'd0, fbctrl_n_out}, 32'd1);
      tick();
      chk_idle_bus("release_a2");
      fidir = 1'b0;
      tick();
      chk("reply_a_rxcnt", {16'd0, rx_cmd_cnt}, 32'd7);

      // Grant off, STBRD trid=7, fidir drops during first TURN cycle
      send_cmd(32'h0000_002B);
      send_cmd(32'h0000_007C);
      fidir = 1'b1;
      tick();
      fidir = 1'b0;
      tick();
      chk_idle_bus("abort1");
      tick();
      chk_idle_bus("abort2");
      // Second window, link full for one edge in TURN
      fidir = 1'b1;
      tick();
      filf_n = 1'b0;
      chk_idle_bus("hold1");
      tick();
      filf_n = 1'b1;
      chk_idle_bus("hold2");
      tick();
      chk_idle_bus("hold3");
      tick();
      chk_reply("reply_b", 32'hA5A5_007C);
      tick();
      chk_idle_bus("release_b");
      fidir = 1'b0;
      tick();

      // Second STBRD while pending overwrites trid and is flagged
      send_cmd(32'h0000_003C);
      send_cmd(32'h0000_009C);
      chk("stbrd2_bad", {24'd0, bad_cmd_cnt}, 32'd2);
      chk("stbrd2_rxcnt", {16'd0, rx_cmd_cnt}, 32'd11);
      fidir = 1'b1;
      tick();
      tick();
      tick();
      chk_reply("reply_c", 32'hA5A5_009C);

      // Reset in the middle of REPLY releases the bus at once
      #1 rst = 1'b1;
      #1;
      chk("rstrep_oe", {31'd0, fbd_oe}, 32'd0);
      chk("rstrep_ten", {31'd0, fbten_n_out}, 32'd1);
      chk("rstrep_ctrl", {31'd0, fbctrl_n_out}, 32'd1);
      chk("rstrep_rxcnt", {16'd0, rx_cmd_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rstrep_noreply", {31'd0, fbd_oe}, 32'd0);
      end
      fidir = 1'b0;
      tick();

      // Counter saturation with 300 undefined commands
      for (int i = 0; i < 300; i++) begin
         send_cmd(32'h0000_0005);
      end
      chk("sat_bad", {24'd0, bad_cmd_cnt}, 32'd255);
      chk("sat_rxcnt", {16'd0, rx_cmd_cnt}, 32'd300);
      chk("sat_txen", {31'd0, tx_enable}, 32'd0);
      send_cmd(32'h0000_0011);
      send_cmd(32'h0000_0007);
      chk("sat_txen_kept", {31'd0, tx_enable}, 32'd1);
      chk("sat_bad_hold", {24'd0, bad_cmd_cnt}, 32'd255);
      chk("sat_rxcnt2", {16'd0, rx_cmd_cnt}, 32'd302);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
